exec_unit_pipe: RTL

EXEC_UNIT_PIPE -- requirements
Module: exec_unit_pipe

---
 rtl/exec_unit_pipe.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit_pipe.sv
// Execution unit: add/sub/mul in a PIPE_LAT-stage pipeline plus an iterative restoring divider,
// latency PIPE_LAT (div DATA_W+1); a held result (cdb_valid && !cdb_ready) freezes every stage and drops in_ready.
module exec_unit_pipe #(
  parameter int DATA_W   = 8,
  parameter int PIPE_LAT = 2,
  parameter int ROB_W    = 3,
  parameter int RS_W     = 3,
  parameter int REG_W    = 4
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_func,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [ROB_W-1:0]    in_rob,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [RS_W-1:0]     in_rs,
  output logic                cdb_valid,
  input  logic                cdb_ready,
  output logic [2*DATA_W-1:0] cdb_data,
  output logic [ROB_W-1:0]    cdb_rob,
  output logic [REG_W-1:0]    cdb_rd,
  output logic [RS_W-1:0]     cdb_rs,
  output logic                cdb_err,
  output logic [2:0]          occupancy
);

  localparam int LAST  = PIPE_LAT - 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_MUL = 4'd2;
  localparam logic [3:0] F_DIV = 4'd3;

  typedef struct packed {
    logic                vld;
    logic                err;
    logic [ROB_W-1:0]    rob;
    logic [REG_W-1:0]    rd;
    logic [RS_W-1:0]     rs;
    logic [2*DATA_W-1:0] dat;
  } stage_t;

  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_e;

  stage_t              stage_q [PIPE_LAT];
  stage_t              stage_d [PIPE_LAT];
  div_state_e          state_q, state_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROB_W-1:0]    div_rob_q, div_rob_d;
  logic [REG_W-1:0]    div_rd_q, div_rd_d;
  logic [RS_W-1:0]     div_rs_q, div_rs_d;
  logic [2:0]          occ_q, occ_d;

  logic                stall;
  logic                pipe_empty;
  logic                is_div;
  logic                accept;
  stage_t              new_op;
  stage_t              div_res;
  logic [2*DATA_W-1:0] first_step;
  logic [2*DATA_W-1:0] next_step;

  // One restoring step: returns {remainder, quotient/dividend shift register}.
  // A zero divisor always "fits", yielding an all-ones quotient and the dividend as remainder.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                   input logic [DATA_W-1:0] quo,
                                                   input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;
    trial = {rem, quo[DATA_W-1]};
    quo_n = quo << 1;
    if (trial >= {1'b0, dvs}) begin
      rem_n    = trial[DATA_W-1:0] - dvs;
      quo_n[0] = 1'b1;
    end else begin
      rem_n = trial[DATA_W-1:0];
    end
    return {rem_n, quo_n};
  endfunction

  always_comb begin
    stall      = stage_q[LAST].vld && !cdb_ready;
    pipe_empty = 1'b1;
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (stage_q[i].vld) pipe_empty = 1'b0;
    end
    is_div   = (in_func == F_DIV);
    in_ready = !rst && !flush && (state_q == IDLE) && !stall && (!is_div || pipe_empty);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    new_op     = '0;
    new_op.vld = accept && !is_div;
    new_op.rob = in_rob;
    new_op.rd  = in_rd;
    new_op.rs  = in_rs;
    case (in_func)
      F_ADD:   new_op.dat = {{DATA_W{1'b0}}, in_a} + {{DATA_W{1'b0}}, in_b};
      F_SUB:   new_op.dat = {{DATA_W{1'b0}}, in_a - in_b};
      F_MUL:   new_op.dat = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
      F_DIV:   new_op.dat = '0;
      default: new_op.err = 1'b1;
    endcase

    div_res     = '0;
    div_res.vld = 1'b1;
    div_res.err = (dvs_q == '0);
    div_res.rob = div_rob_q;
    div_res.rd  = div_rd_q;
    div_res.rs  = div_rs_q;
    div_res.dat = {rem_q, quo_q};

    first_step = div_step('0, in_a, in_b);
    next_step  = div_step(rem_q, quo_q, dvs_q);
  end

  always_comb begin
    stage_d   = stage_q;
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    div_rob_d = div_rob_q;
    div_rd_d  = div_rd_q;
    div_rs_d  = div_rs_q;
    occ_d     = '0;

    if (!stall) begin
      for (int i = LAST; i > 0; i--) stage_d[i] = stage_q[i-1];
      stage_d[0] = new_op;
    end

    // The acceptance edge already performs the first quotient bit, so DIV
    // holds for DATA_W-1 cycles and DONE hands off one cycle later.
    case (state_q)
      IDLE: begin
        if (accept && is_div) begin
          {rem_d, quo_d} = first_step;
          dvs_d          = in_b;
          cnt_d          = CNT_W'(1);
          div_rob_d      = in_rob;
          div_rd_d       = in_rd;
          div_rs_d       = in_rs;
          state_d        = (DATA_W == 1) ? DONE : DIV;
        end
      end
      DIV: begin
        {rem_d, quo_d} = next_step;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (!stall) begin
          stage_d[LAST] = div_res;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      for (int i = 0; i < PIPE_LAT; i++) stage_d[i].vld = 1'b0;
      state_d = IDLE;
    end

    for (int i = 0; i < PIPE_LAT; i++) occ_d = occ_d + {2'b00, stage_d[i].vld};
    if (state_d != IDLE) occ_d = occ_d + 3'd1;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) stage_q[i] <= '0;
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      div_rob_q <= '0;
      div_rd_q  <= '0;
      div_rs_q  <= '0;
      occ_q     <= '0;
    end else begin
      for (int i = 0; i < PIPE_LAT; i++) stage_q[i] <= stage_d[i];
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      div_rob_q <= div_rob_d;
      div_rd_q  <= div_rd_d;
      div_rs_q  <= div_rs_d;
      occ_q     <= occ_d;
    end
  end

  assign cdb_valid = stage_q[LAST].vld;
  assign cdb_data  = stage_q[LAST].dat;
  assign cdb_rob   = stage_q[LAST].rob;
  assign cdb_rd    = stage_q[LAST].rd;
  assign cdb_rs    = stage_q[LAST].rs;
  assign cdb_err   = stage_q[LAST].err;
  assign occupancy = occ_q;

endmodule
